// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: program-load port, run/redirect control, output
// handshake and status.
//   master : driven by the controller/downstream side (load_*, run,
//            redirect_*, out_ready); observes out_*, busy, halted
//   slave  : the fetch unit itself
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               run;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_ready;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               busy;
  logic               halted;

  modport master (
    output load_en, load_addr, load_data, run, redirect_valid, redirect_pc, out_ready,
    input  out_valid, out_instr, out_pc, busy, halted
  );

  modport slave (
    input  load_en, load_addr, load_data, run, redirect_valid, redirect_pc, out_ready,
    output out_valid, out_instr, out_pc, busy, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: private instruction memory with a program-load
// write port, sequential fetch from RESET_PC on each run, redirect support
// and a one-entry valid/ready output register. Fetching stops once HALT_WORD
// has been captured.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_unit_if.slave (load port, run, redirect,
//                out_valid/out_ready/out_instr/out_pc, busy, halted)
module instr_fetch_unit #(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD = '1
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  logic [INSTR_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

  logic               run_st, wr_en, issue;
  logic [INSTR_W-1:0] rd_word;

  assign run_st  = (state_q == S_RUN);
  assign wr_en   = bus.load_en && !run_st;
  // A read may only issue when the output register is free at the next edge.
  assign issue   = run_st && !bus.redirect_valid && (!out_valid_q || bus.out_ready);
  assign rd_word = mem_q[pc_q];

  // Memory is not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[bus.load_addr] <= bus.load_data;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    case (state_q)
      S_RUN: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
        end else if (issue) begin
          pc_d = pc_q + PC_ONE;
          // Leaving RUN here guarantees no read issues after the halt word.
          if (rd_word == HALT_WORD) state_d = S_HALT;
        end
      end
      default: begin
        if (bus.run) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
    endcase

    // The output register doubles as the memory read register, so data
    // issued this cycle is presented next cycle.
    if (run_st && bus.redirect_valid) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d = 1'b1;
      out_instr_d = rd_word;
      out_pc_d    = pc_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.busy      = run_st;
  assign bus.halted    = (state_q == S_HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00), .HALT_WORD(16'hFFFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        exp_q [$];
  logic [15:0] tb_mem [256];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
    tick();
    bus.load_en = 1'b0;
    tb_mem[a] = d;
  endtask

  // Expected fetch stream from 'start' up to and including the halt word.
  task automatic push_prog(input logic [7:0] start);
    logic [7:0] a;
    a = start;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{a, tb_mem[a]});
      if (tb_mem[a] == 16'hFFFF) break;
      a = a + 8'd1;
    end
  endtask

  task automatic pulse_run();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  task automatic wait_halt();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.halted && !bus.out_valid) ok = 1'b1;
      else tick();
    end
    chk("halt_wait", {31'd0, ok}, 32'd1);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_pc(input logic [7:0] p);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.out_valid && bus.out_pc == p) ok = 1'b1;
      else tick();
    end
    chk("pc_wait", {31'd0, ok}, 32'd1);
  endtask

  // Scoreboard: a transfer is valid&ready on a cycle without a flush.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexp_out", {24'd0, bus.out_pc}, 32'hFFFF_FFFF);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("sb_pc", {24'd0, bus.out_pc}, {24'd0, e.pc});
        chk("sb_instr", {16'd0, bus.out_instr}, {16'd0, e.instr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0000;
    bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
    bus.run = 0; bus.redirect_valid = 0; bus.redirect_pc = '0; bus.out_ready = 1;

    // Reset state
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_halted", bus.halted, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic three-word program with halt
    load(8'd0, 16'h1234); load(8'd1, 16'h5678); load(8'd2, 16'hFFFF);
    push_prog(8'd0);
    pulse_run();
    chk("t1_lat_valid", bus.out_valid, 0);
    chk("t1_busy", bus.busy, 1);
    tick();
    chk("t1_v0", bus.out_valid, 1); chk("t1_pc0", bus.out_pc, 0); chk("t1_i0", bus.out_instr, 16'h1234);
    tick();
    chk("t1_pc1", bus.out_pc, 1); chk("t1_i1", bus.out_instr, 16'h5678);
    tick();
    chk("t1_pc2", bus.out_pc, 2); chk("t1_i2", bus.out_instr, 16'hFFFF);
    chk("t1_halted", bus.halted, 1); chk("t1_busy_lo", bus.busy, 0);
    tick();
    chk("t1_no_more", bus.out_valid, 0);
    wait_halt();

    // Backpressure at pc 1
    for (int i = 0; i < 7; i++) load(i[7:0], 16'h1000 + 16'(i));
    load(8'd7, 16'hFFFF);
    bus.out_ready = 0;
    push_prog(8'd0);
    pulse_run();
    tick();
    chk("t2_pc0", bus.out_pc, 0);
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_pc", bus.out_pc, 1);
      chk("t2_hold_i", bus.out_instr, 16'h1001);
      tick();
    end
    chk("t2_still_pc", bus.out_pc, 1);
    bus.out_ready = 1;
    tick();
    chk("t2_resume", bus.out_pc, 2);
    wait_halt();

    // Redirect while pc 5 is next
    load(8'h40, 16'h2040); load(8'h41, 16'h2041); load(8'h42, 16'h2042); load(8'h43, 16'hFFFF);
    for (int i = 0; i < 4; i++) exp_q.push_back('{i[7:0], tb_mem[i]});
    push_prog(8'h40);
    pulse_run();
    wait_pc(8'd4);
    bus.redirect_valid = 1; bus.redirect_pc = 8'h40;
    tick();
    bus.redirect_valid = 0;
    chk("t3_flush", bus.out_valid, 0);
    tick();
    chk("t3_v", bus.out_valid, 1);
    chk("t3_pc", bus.out_pc, 8'h40);
    wait_halt();

    // Address wrap
    load(8'hFE, 16'h30FE); load(8'hFF, 16'h30FF);
    push_prog(8'hFE);
    pulse_run();
    bus.redirect_valid = 1; bus.redirect_pc = 8'hFE;
    tick();
    bus.redirect_valid = 0;
    chk("t4_flush", bus.out_valid, 0);
    tick(); chk("t4_fe", bus.out_pc, 8'hFE);
    tick(); chk("t4_ff", bus.out_pc, 8'hFF);
    tick(); chk("t4_wrap", bus.out_pc, 8'h00);
    wait_halt();

    // Load ignored in RUN, reset mid-run, re-run with load+run together
    push_prog(8'd0);
    pulse_run();
    bus.load_en = 1; bus.load_addr = 8'd3; bus.load_data = 16'hBEEF;
    tick();
    bus.load_en = 0;
    wait_pc(8'd3);
    chk("t5_w3", bus.out_instr, 16'h1003);
    tick();
    rst_n = 0;
    #1;
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_halt", bus.halted, 0);
    exp_q.delete();
    tick();
    rst_n = 1;
    tick();
    tick();
    chk("t5_idle", bus.busy, 0);
    chk("t5_idle_v", bus.out_valid, 0);
    tb_mem[0] = 16'h1ABC;
    push_prog(8'd0);
    bus.load_en = 1; bus.load_addr = 8'd0; bus.load_data = 16'h1ABC; bus.run = 1;
    tick();
    bus.load_en = 0; bus.run = 0;
    tick();
    chk("t5_fwd_pc", bus.out_pc, 0);
    chk("t5_fwd_i", bus.out_instr, 16'h1ABC);
    wait_halt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, PC and memory address width.
REQ-002 Parameter INSTR_W, default 16, instruction word width.
REQ-003 Parameter RESET_PC, default 0, start address after reset and on each run.
REQ-004 Parameter HALT_WORD, default all-ones of INSTR_W, instruction value that stops fetching.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 load_en  input  1  write strobe for the program-load port.
REQ-008 load_addr  input  ADDR_W  program-load write address.
REQ-009 load_data  input  INSTR_W  program-load write data.
REQ-010 run  input  1  start pulse, sampled in IDLE or HALT.
REQ-011 redirect_valid  input  1  branch/jump redirect request.
REQ-012 redirect_pc  input  ADDR_W  redirect target.
REQ-013 out_ready  input  1  downstream accepts the current instruction.
REQ-014 out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
REQ-015 out_instr  output  INSTR_W  fetched instruction.
REQ-016 out_pc  output  ADDR_W  address from which out_instr was fetched.
REQ-017 busy  output  1  high while in state RUN.
REQ-018 halted  output  1  high while in state HALT.

Function
REQ-019 Memory SHALL hold 2**ADDR_W words of INSTR_W, one synchronous write port and one synchronous read port, read data one cycle after address issue; contents are not reset.
REQ-020 States SHALL be IDLE, RUN, HALT; IDLE->RUN on run, HALT->RUN on run, RUN->HALT when a fetched word equal to HALT_WORD is captured into the output register, RUN->IDLE never except by reset.
REQ-021 On run, pc SHALL be loaded with RESET_PC; first read issues in the following cycle.
REQ-022 A write SHALL occur when load_en is high in IDLE or HALT; load_en in RUN SHALL be ignored.
REQ-023 load_en and run in the same cycle SHALL perform the write, and the first fetch SHALL return the written data if addresses match.
REQ-024 In RUN a read of pc SHALL issue in any cycle where (!out_valid || out_ready) and redirect_valid is low; pc then increments by 1 modulo 2**ADDR_W (2**ADDR_W-1 wraps to 0).
REQ-025 Read data SHALL land in the output register the cycle after issue with out_valid=1 and out_pc=issued address; sustained throughput one instruction per cycle while out_ready=1.
REQ-026 out_valid with out_ready low SHALL hold out_instr/out_pc stable and issue no new read.
REQ-027 redirect_valid in RUN SHALL set pc to redirect_pc, clear out_valid, squash any in-flight read (its data never appears), and issue no read that cycle; first redirected read issues next cycle.
REQ-028 redirect_valid outside RUN SHALL be ignored.
REQ-029 On capturing HALT_WORD no further reads SHALL issue; the HALT_WORD entry SHALL still be presented and held until accepted.
REQ-030 run while in RUN SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, busy=0, halted=0, and discard any in-flight read; memory contents are retained.
REQ-032 Reset deasserted mid-run SHALL leave the block in IDLE awaiting run.

Verification
REQ-033 Load 0x1234,0x5678,0xFFFF at 0..2, pulse run, out_ready=1 -> out (pc,instr) = (0,0x1234),(1,0x5678),(2,0xFFFF) on consecutive cycles, then halted=1, busy=0, no more out_valid.
REQ-034 Running with out_ready=0 for 3 cycles at pc 1 -> out_pc=1 and out_instr held 3 cycles, then sequence resumes with pc 2 the cycle after out_ready returns, no skip or duplicate.
REQ-035 redirect_valid with redirect_pc=0x40 while pc=5 in flight -> instruction from 5 never valid; next valid out_pc=0x40 two cycles after redirect.
REQ-036 Non-halt words at 0xFE,0xFF, redirect to 0xFE -> out_pc 0xFE, 0xFF, 0x00 (wrap).
REQ-037 load_en during RUN to address 3 -> memory word 3 unchanged on later fetch; rst_n low mid-run -> out_valid=0 same cycle, busy=0, previously loaded program re-runs identically after new run.
